rx_libnet_seq: RTL and testbench

- Parametrised successor of the 512-bit reliable Libnet receiver.
- Sits between the MAC RX AXIS stream and upper Libnet layers, and tracks an independent expected sequence number per channel (channel ID carried in tuser).
- Forwards in-order packets and silently drops duplicate and out-of-order packets.
- Emits a one-cycle ACK/NACK event per decision for the Libnet TX side to turn into reliability frames.

---
 rtl/rx_libnet_seq.sv | 177 +++++++++++++++++
 tb/tb_rx_libnet_seq.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_libnet_seq.sv
// Reliable Libnet receiver: per-channel in-order sequence tracking on an AXIS stream.
// Forwards in-order packets through one output register and reports ACK/NACK events.
module rx_libnet_seq #(
    parameter int unsigned DATA_WIDTH  = 512,
    parameter int unsigned USER_WIDTH  = 64,
    parameter int unsigned SEQ_WIDTH   = 16,
    parameter int unsigned SEQ_OFFSET  = 0,
    parameter int unsigned CHAN_WIDTH  = 2,
    parameter int unsigned CHAN_OFFSET = 0,
    parameter int unsigned DUP_WINDOW  = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [DATA_WIDTH-1:0]   rx_tdata,
    input  logic [DATA_WIDTH/8-1:0] rx_tkeep,
    input  logic [USER_WIDTH-1:0]   rx_tuser,
    input  logic                    rx_tvalid,
    input  logic                    rx_tlast,
    output logic                    rx_tready,
    output logic [DATA_WIDTH-1:0]   tx_tdata,
    output logic [DATA_WIDTH/8-1:0] tx_tkeep,
    output logic [USER_WIDTH-1:0]   tx_tuser,
    output logic                    tx_tvalid,
    output logic                    tx_tlast,
    input  logic                    tx_tready,
    output logic                    ack_valid,
    output logic                    ack_nack,
    output logic [CHAN_WIDTH-1:0]   ack_chan,
    output logic [SEQ_WIDTH-1:0]    ack_seq,
    output logic [31:0]             drop_count
);

    localparam int unsigned NUM_CHAN = 2 ** CHAN_WIDTH;

    localparam logic [1:0] ST_HEAD = 2'd0;
    localparam logic [1:0] ST_PASS = 2'd1;
    localparam logic [1:0] ST_DROP = 2'd2;

    logic [1:0]            state;
    logic [1:0]            state_next;
    logic [SEQ_WIDTH-1:0]  expected [NUM_CHAN];
    logic [CHAN_WIDTH-1:0] cur_chan;
    logic [SEQ_WIDTH-1:0]  cur_seq;

    logic [CHAN_WIDTH-1:0] head_chan;
    logic [SEQ_WIDTH-1:0]  head_seq;
    logic [SEQ_WIDTH-1:0]  head_exp;
    logic [SEQ_WIDTH-1:0]  head_dist;
    logic                  in_order;
    logic                  is_dup;
    logic                  hs;

    logic                  load;
    logic                  complete;
    logic                  drop_evt;
    logic [CHAN_WIDTH-1:0] done_chan;
    logic [SEQ_WIDTH-1:0]  done_seq;

    // Head-beat classification against the channel's expected sequence.
    assign head_chan = rx_tuser[CHAN_OFFSET +: CHAN_WIDTH];
    assign head_seq  = rx_tdata[SEQ_OFFSET +: SEQ_WIDTH];
    assign head_exp  = expected[head_chan];
    assign head_dist = head_exp - head_seq;
    assign in_order  = (head_dist == '0);
    assign is_dup    = !in_order && (head_dist <= SEQ_WIDTH'(DUP_WINDOW));

    // Dropped beats never touch the output register, so DROP never stalls.
    assign rx_tready = (state == ST_DROP) || !tx_tvalid || tx_tready;
    assign hs        = rx_tvalid && rx_tready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_HEAD;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        complete   = 1'b0;
        drop_evt   = 1'b0;
        done_chan  = cur_chan;
        done_seq   = cur_seq;
        case (state)
            ST_HEAD: begin
                if (hs) begin
                    done_chan = head_chan;
                    done_seq  = head_seq;
                    if (in_order) begin
                        load = 1'b1;
                        if (rx_tlast) begin
                            complete = 1'b1;
                        end else begin
                            state_next = ST_PASS;
                        end
                    end else begin
                        drop_evt = 1'b1;
                        if (!rx_tlast) begin
                            state_next = ST_DROP;
                        end
                    end
                end
            end
            ST_PASS: begin
                if (hs) begin
                    load = 1'b1;
                    if (rx_tlast) begin
                        complete   = 1'b1;
                        state_next = ST_HEAD;
                    end
                end
            end
            ST_DROP: begin
                if (hs && rx_tlast) begin
                    state_next = ST_HEAD;
                end
            end
            default: state_next = ST_HEAD;
        endcase
    end

    // Datapath: packet context, output register, sequence table, events, drop counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_CHAN; i++) begin
                expected[i] <= '0;
            end
            cur_chan   <= '0;
            cur_seq    <= '0;
            tx_tdata   <= '0;
            tx_tkeep   <= '0;
            tx_tuser   <= '0;
            tx_tvalid  <= 1'b0;
            tx_tlast   <= 1'b0;
            ack_valid  <= 1'b0;
            ack_nack   <= 1'b0;
            ack_chan   <= '0;
            ack_seq    <= '0;
            drop_count <= '0;
        end else begin
            if (state == ST_HEAD && hs) begin
                cur_chan <= head_chan;
                cur_seq  <= head_seq;
            end

            if (load) begin
                tx_tdata  <= rx_tdata;
                tx_tkeep  <= rx_tkeep;
                tx_tuser  <= rx_tuser;
                tx_tlast  <= rx_tlast;
                tx_tvalid <= 1'b1;
            end else if (tx_tready) begin
                tx_tvalid <= 1'b0;
            end

            ack_valid <= 1'b0;
            if (complete) begin
                expected[done_chan] <= done_seq + SEQ_WIDTH'(1);
                ack_valid <= 1'b1;
                ack_nack  <= 1'b0;
                ack_chan  <= done_chan;
                ack_seq   <= done_seq;
            end else if (drop_evt) begin
                ack_valid <= 1'b1;
                ack_nack  <= !is_dup;
                ack_chan  <= head_chan;
                ack_seq   <= is_dup ? (head_exp - SEQ_WIDTH'(1)) : head_exp;
                if (drop_count != 32'hFFFF_FFFF) begin
                    drop_count <= drop_count + 32'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_rx_libnet_seq.sv
// Directed bench for rx_libnet_seq: ordering, gaps, duplicates, wrap, backpressure, reset.
module tb_rx_libnet_seq;

    localparam int unsigned DW = 512;
    localparam int unsigned UW = 64;
    localparam int unsigned SW = 12;
    localparam int unsigned CW = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic [DW-1:0]   rx_tdata;
    logic [DW/8-1:0] rx_tkeep;
    logic [UW-1:0]   rx_tuser;
    logic            rx_tvalid;
    logic            rx_tlast;
    logic            rx_tready;
    logic [DW-1:0]   tx_tdata;
    logic [DW/8-1:0] tx_tkeep;
    logic [UW-1:0]   tx_tuser;
    logic            tx_tvalid;
    logic            tx_tlast;
    logic            tx_tready;
    logic            ack_valid;
    logic            ack_nack;
    logic [CW-1:0]   ack_chan;
    logic [SW-1:0]   ack_seq;
    logic [31:0]     drop_count;

    int total = 0;
    int bad   = 0;

    rx_libnet_seq #(
        .DATA_WIDTH (DW),
        .USER_WIDTH (UW),
        .SEQ_WIDTH  (SW),
        .SEQ_OFFSET (0),
        .CHAN_WIDTH (CW),
        .CHAN_OFFSET(0),
        .DUP_WINDOW (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_tdata  (rx_tdata),
        .rx_tkeep  (rx_tkeep),
        .rx_tuser  (rx_tuser),
        .rx_tvalid (rx_tvalid),
        .rx_tlast  (rx_tlast),
        .rx_tready (rx_tready),
        .tx_tdata  (tx_tdata),
        .tx_tkeep  (tx_tkeep),
        .tx_tuser  (tx_tuser),
        .tx_tvalid (tx_tvalid),
        .tx_tlast  (tx_tlast),
        .tx_tready (tx_tready),
        .ack_valid (ack_valid),
        .ack_nack  (ack_nack),
        .ack_chan  (ack_chan),
        .ack_seq   (ack_seq),
        .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Beat layout: seq in [15:0], payload tag in [63:32]; tkeep mirrors the tag.
    task automatic drive(input logic [1:0] ch, input logic [15:0] seq,
                         input logic [31:0] pay, input logic last);
        rx_tdata          = '0;
        rx_tdata[15:0]    = seq;
        rx_tdata[63:32]   = pay;
        rx_tkeep          = 64'(pay);
        rx_tuser          = '0;
        rx_tuser[1:0]     = ch;
        rx_tuser[63:48]   = 16'hA5A5;
        rx_tlast          = last;
        rx_tvalid         = 1'b1;
    endtask

    task automatic beat(input logic [1:0] ch, input logic [15:0] seq,
                        input logic [31:0] pay, input logic last);
        logic ok;
        int   n;
        ok = 1'b0;
        n  = 0;
        drive(ch, seq, pay, last);
        while (!ok && n < 50) begin
            @(negedge clk);
            ok = rx_tready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!ok) chk("hs_timeout", 64'(ok), 64'd1);
        rx_tvalid = 1'b0;
        rx_tlast  = 1'b0;
    endtask

    task automatic chk_fwd(input string tag, input logic [1:0] ch, input logic [15:0] seq,
                           input logic [31:0] pay, input logic last);
        logic [63:0] u;
        u        = '0;
        u[1:0]   = ch;
        u[63:48] = 16'hA5A5;
        chk({tag, "_tvalid"}, 64'(tx_tvalid), 64'd1);
        chk({tag, "_tdata"}, tx_tdata[63:0], {pay, 16'h0, seq});
        chk({tag, "_tlast"}, 64'(tx_tlast), 64'(last));
        chk({tag, "_tkeep"}, tx_tkeep, 64'(pay));
        chk({tag, "_tuser"}, tx_tuser, u);
    endtask

    task automatic chk_ack(input string tag, input logic nack, input logic [1:0] ch,
                           input logic [15:0] seq);
        chk({tag, "_ack_valid"}, 64'(ack_valid), 64'd1);
        chk({tag, "_ack_nack"}, 64'(ack_nack), 64'(nack));
        chk({tag, "_ack_chan"}, 64'(ack_chan), 64'(ch));
        chk({tag, "_ack_seq"}, 64'(ack_seq), 64'(seq));
    endtask

    initial begin
        reset     = 1'b1;
        rx_tdata  = '0;
        rx_tkeep  = '0;
        rx_tuser  = '0;
        rx_tvalid = 1'b0;
        rx_tlast  = 1'b0;
        tx_tready = 1'b1;
        repeat (3) step();

        chk("rst_tvalid", 64'(tx_tvalid), 64'd0);
        chk("rst_tlast", 64'(tx_tlast), 64'd0);
        chk("rst_tdata", tx_tdata[63:0], 64'd0);
        chk("rst_ack_valid", 64'(ack_valid), 64'd0);
        chk("rst_ack_seq", 64'(ack_seq), 64'd0);
        chk("rst_drop", 64'(drop_count), 64'd0);
        reset = 1'b0;
        step();

        // In-order 3-beat packets on channel 0
        for (int p = 0; p < 3; p++) begin
            for (int b = 0; b < 3; b++) begin
                beat(2'd0, 16'(p), 32'(16 * p + b + 1), b == 2);
                chk_fwd("t1_fwd", 2'd0, 16'(p), 32'(16 * p + b + 1), b == 2);
                if (b == 2) chk_ack("t1", 1'b0, 2'd0, 16'(p));
                else        chk("t1_no_ack", 64'(ack_valid), 64'd0);
            end
        end
        step();
        chk("t1_idle_tvalid", 64'(tx_tvalid), 64'd0);
        chk("t1_drop", 64'(drop_count), 64'd0);

        // Gap on channel 1: bring expected to 5, send 7, then 5
        for (int q = 0; q < 5; q++) beat(2'd1, 16'(q), 32'(100 + q), 1'b1);
        chk_ack("t2_pre", 1'b0, 2'd1, 16'd4);
        beat(2'd1, 16'd7, 32'h200, 1'b0);
        chk("t2_gap_tvalid", 64'(tx_tvalid), 64'd0);
        chk_ack("t2_gap", 1'b1, 2'd1, 16'd5);
        chk("t2_gap_drop", 64'(drop_count), 64'd1);
        beat(2'd1, 16'd7, 32'h201, 1'b1);
        chk("t2_gap_b1_tvalid", 64'(tx_tvalid), 64'd0);
        chk("t2_gap_b1_ack", 64'(ack_valid), 64'd0);
        beat(2'd1, 16'd5, 32'h205, 1'b1);
        chk_fwd("t2_fill", 2'd1, 16'd5, 32'h205, 1'b1);
        chk_ack("t2_fill", 1'b0, 2'd1, 16'd5);

        // Duplicate on channel 2: expected 10, send 8, then 10 still accepted
        for (int q = 0; q < 10; q++) beat(2'd2, 16'(q), 32'(300 + q), 1'b1);
        beat(2'd2, 16'd8, 32'h308, 1'b1);
        chk("t3_dup_tvalid", 64'(tx_tvalid), 64'd0);
        chk_ack("t3_dup", 1'b0, 2'd2, 16'd9);
        chk("t3_dup_drop", 64'(drop_count), 64'd2);
        beat(2'd2, 16'd10, 32'h30A, 1'b1);
        chk_fwd("t3_next", 2'd2, 16'd10, 32'h30A, 1'b1);
        chk_ack("t3_next", 1'b0, 2'd2, 16'd10);

        // Wrap channel 0 at 12 bits, channel 3 independent
        beat(2'd3, 16'd0, 32'h400, 1'b1);
        chk_ack("t4_c3a", 1'b0, 2'd3, 16'd0);
        for (int q = 3; q <= 12'hFFE; q++) beat(2'd0, 16'(q), 32'(q), 1'b1);
        chk_ack("t4_pre", 1'b0, 2'd0, 16'hFFE);
        beat(2'd0, 16'hFFF, 32'h4FF, 1'b1);
        chk_fwd("t4_max", 2'd0, 16'hFFF, 32'h4FF, 1'b1);
        chk_ack("t4_max", 1'b0, 2'd0, 16'hFFF);
        beat(2'd0, 16'd0, 32'h500, 1'b1);
        chk_fwd("t4_wrap", 2'd0, 16'd0, 32'h500, 1'b1);
        chk_ack("t4_wrap", 1'b0, 2'd0, 16'd0);
        beat(2'd3, 16'd1, 32'h401, 1'b1);
        chk_ack("t4_c3b", 1'b0, 2'd3, 16'd1);
        chk("t4_drop", 64'(drop_count), 64'd2);

        // Backpressure toggling on a 4-beat in-order packet (ch0 seq 1)
        step();
        chk("t5_idle", 64'(tx_tvalid), 64'd0);
        drive(2'd0, 16'd1, 32'h600, 1'b0);
        tx_tready = 1'b0;
        step();
        chk_fwd("t5_b0", 2'd0, 16'd1, 32'h600, 1'b0);
        drive(2'd0, 16'd1, 32'h601, 1'b0);
        chk("t5_stall1_rdy", 64'(rx_tready), 64'd0);
        step();
        chk_fwd("t5_hold0", 2'd0, 16'd1, 32'h600, 1'b0);
        tx_tready = 1'b1;
        #1;
        chk("t5_go1_rdy", 64'(rx_tready), 64'd1);
        step();
        chk_fwd("t5_b1", 2'd0, 16'd1, 32'h601, 1'b0);
        drive(2'd0, 16'd1, 32'h602, 1'b0);
        tx_tready = 1'b0;
        #1;
        chk("t5_stall2_rdy", 64'(rx_tready), 64'd0);
        step();
        chk_fwd("t5_hold1", 2'd0, 16'd1, 32'h601, 1'b0);
        tx_tready = 1'b1;
        step();
        chk_fwd("t5_b2", 2'd0, 16'd1, 32'h602, 1'b0);
        drive(2'd0, 16'd1, 32'h603, 1'b1);
        tx_tready = 1'b0;
        step();
        chk_fwd("t5_hold2", 2'd0, 16'd1, 32'h602, 1'b0);
        chk("t5_hold2_ack", 64'(ack_valid), 64'd0);
        tx_tready = 1'b1;
        step();
        chk_fwd("t5_b3", 2'd0, 16'd1, 32'h603, 1'b1);
        chk_ack("t5", 1'b0, 2'd0, 16'd1);
        rx_tvalid = 1'b0;
        rx_tlast  = 1'b0;
        step();
        chk("t5_drain", 64'(tx_tvalid), 64'd0);

        // Dropped packet ignores tx_tready (ch0 expected 2, seq 0 is a duplicate)
        beat(2'd0, 16'd0, 32'h700, 1'b0);
        chk_ack("t5_dup", 1'b0, 2'd0, 16'd1);
        chk("t5_dup_drop", 64'(drop_count), 64'd3);
        tx_tready = 1'b0;
        drive(2'd0, 16'd0, 32'h701, 1'b0);
        #1;
        chk("t5_drop_rdy1", 64'(rx_tready), 64'd1);
        step();
        drive(2'd0, 16'd0, 32'h702, 1'b1);
        #1;
        chk("t5_drop_rdy2", 64'(rx_tready), 64'd1);
        step();
        rx_tvalid = 1'b0;
        rx_tlast  = 1'b0;
        chk("t5_drop_tvalid", 64'(tx_tvalid), 64'd0);
        chk("t5_drop_ack", 64'(ack_valid), 64'd0);
        tx_tready = 1'b1;

        // Mid-packet reset on beat 2 of a 4-beat ch1 packet (expected 6)
        beat(2'd1, 16'd6, 32'h800, 1'b0);
        chk_fwd("t6_b0", 2'd1, 16'd6, 32'h800, 1'b0);
        beat(2'd1, 16'd6, 32'h801, 1'b0);
        drive(2'd1, 16'd6, 32'h802, 1'b0);
        reset = 1'b1;
        step();
        reset     = 1'b0;
        rx_tvalid = 1'b0;
        chk("t6_rst_tvalid", 64'(tx_tvalid), 64'd0);
        chk("t6_rst_tdata", tx_tdata[63:0], 64'd0);
        chk("t6_rst_drop", 64'(drop_count), 64'd0);
        chk("t6_rst_ack", 64'(ack_valid), 64'd0);
        beat(2'd1, 16'd0, 32'h900, 1'b1);
        chk_fwd("t6_head", 2'd1, 16'd0, 32'h900, 1'b1);
        chk_ack("t6_head", 1'b0, 2'd1, 16'd0);
        beat(2'd2, 16'd0, 32'h901, 1'b1);
        chk_ack("t6_c2", 1'b0, 2'd2, 16'd0);
        chk("t6_drop", 64'(drop_count), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
